// File: rtl/ioreg_cfg_pkg.sv
// Shared definitions for the ioreg configuration loader: field layout,
// sequencing states and width helpers.
package ioreg_cfg_pkg;

  localparam int CFG_W = 4;

  // Bit positions inside one IO's config nibble {INEN,OQE,OSEL,ESEL}.
  localparam int ESEL = 0;
  localparam int OSEL = 1;
  localparam int OQE  = 2;
  localparam int INEN = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FREEZE  = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(CFG_W * n);
  endfunction

endpackage

// File: rtl/ioreg_cfg_ser.sv
// Parallel-to-serial path: captures the shadow snapshot, then emits it MSB
// first (highest IO, bit3 first) on a registered serial output.
module ioreg_cfg_ser
  import ioreg_cfg_pkg::*;
#(
  parameter int NUM_IO = 32
) (
  input  logic                       QCK,
  input  logic                       QRT,
  input  logic                       load,
  input  logic                       prime,
  input  logic                       shift,
  input  logic [CFG_W*NUM_IO-1:0]    data,
  output logic                       last,
  output logic                       sdo
);

  localparam int TOT   = CFG_W * NUM_IO;
  localparam int CNT_W = cnt_width(NUM_IO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOT - 1);

  logic [TOT-1:0]   snap;
  logic [CNT_W-1:0] cnt;

  assign last = shift && (cnt == CNT_LAST);

  // The snapshot is consumed from the top; prime pre-loads the first bit so
  // sdo is already valid in the first SHIFT cycle.
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      snap <= '0;
      cnt  <= '0;
      sdo  <= 1'b0;
    end else begin
      if (load) begin
        snap <= data;
      end else if (prime || (shift && !last)) begin
        snap <= {snap[TOT-2:0], 1'b0};
      end

      if (prime) begin
        sdo <= snap[TOT-1];
        cnt <= '0;
      end else if (shift) begin
        if (last) begin
          sdo <= 1'b0;
          cnt <= '0;
        end else begin
          sdo <= snap[TOT-1];
          cnt <= cnt + 1'b1;
        end
      end else begin
        sdo <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ioreg_cfg_loader.sv
// Shadow config store for an ioreg chain plus the freeze/shift/latch/release
// sequencer that pushes the shadow onto the chain on commit.
//
// state   | meaning
// IDLE    | shadow writable, pads run from active config
// FREEZE  | fixhold up, snapshot held, first bit primed
// SHIFT   | 4*NUM_IO chain shift cycles
// LATCH   | chain transferred into ioreg active config
// RELEASE | fixhold dropped next cycle, done pulse
module ioreg_cfg_loader
  import ioreg_cfg_pkg::*;
#(
  parameter int         NUM_IO  = 32,
  parameter logic [3:0] RST_CFG = 4'b0000
) (
  input  logic                           QCK,
  input  logic                           QRT,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [idx_width(NUM_IO)-1:0]   wr_idx,
  input  logic [CFG_W-1:0]               wr_cfg,
  input  logic                           commit,
  output logic                           busy,
  output logic                           done,
  output logic                           chain_sdo,
  output logic                           chain_shift,
  output logic                           chain_latch,
  output logic                           fixhold
);

  localparam int IDX_W = idx_width(NUM_IO);
  localparam int TOT   = CFG_W * NUM_IO;

  state_t state_q, state_d;

  logic [TOT-1:0] shadow_q, shadow_d;
  logic           ser_last;
  logic           snap_load;

  // Indices at or beyond NUM_IO match no slot and are silently dropped.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_valid && wr_ready) begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          shadow_d[i*CFG_W +: CFG_W] = wr_cfg;
        end
      end
    end
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      shadow_q <= {NUM_IO{RST_CFG}};
    end else begin
      shadow_q <= shadow_d;
    end
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b1;
    fixhold     = 1'b1;
    chain_shift = 1'b0;
    chain_latch = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy    = 1'b0;
        fixhold = 1'b0;
        if (commit) state_d = ST_FREEZE;
      end
      ST_FREEZE: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        chain_shift = 1'b1;
        if (ser_last) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        chain_latch = 1'b1;
        state_d     = ST_RELEASE;
      end
      ST_RELEASE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wr_ready = !busy;

  // Snapshot from shadow_d so a write accepted alongside commit is included.
  assign snap_load = (state_q == ST_IDLE) && commit;

  ioreg_cfg_ser #(
    .NUM_IO (NUM_IO)
  ) u_ser (
    .QCK   (QCK),
    .QRT   (QRT),
    .load  (snap_load),
    .prime (state_q == ST_FREEZE),
    .shift (state_q == ST_SHIFT),
    .data  (shadow_d),
    .last  (ser_last),
    .sdo   (chain_sdo)
  );

endmodule

// File: tb/tb_ioreg_cfg_loader.sv
// Self-checking bench for ioreg_cfg_loader with NUM_IO=4 against an
// array-based model of the shadow and the chain bit order.
module tb_ioreg_cfg_loader;

  localparam int N    = 4;
  localparam int BITS = 4 * N;

  logic       QCK = 1'b0;
  logic       QRT;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_idx;
  logic [3:0] wr_cfg;
  logic       commit;
  logic       busy, done, chain_sdo, chain_shift, chain_latch, fixhold;

  int total = 0;
  int bad   = 0;
  int model [N];

  ioreg_cfg_loader #(
    .NUM_IO  (N),
    .RST_CFG (4'b0000)
  ) dut (
    .QCK         (QCK),
    .QRT         (QRT),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_cfg      (wr_cfg),
    .commit      (commit),
    .busy        (busy),
    .done        (done),
    .chain_sdo   (chain_sdo),
    .chain_shift (chain_shift),
    .chain_latch (chain_latch),
    .fixhold     (fixhold)
  );

  always #5 QCK = ~QCK;

  // Chain position j: IO (N-1 - j/4), bit (3 - j%4).
  function automatic logic exp_bit(input int j);
    logic [3:0] v;
    v = model[N-1 - j/4][3:0];
    return v[3 - j%4];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = 0;
  endtask

  task automatic write_io(input int idx, input logic [3:0] cfg);
    @(negedge QCK);
    total++;
    if (wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL write_ready idx=%0d got=%b want=1", idx, wr_ready);
    end
    wr_valid = 1'b1;
    wr_idx   = idx[1:0];
    wr_cfg   = cfg;
    model[idx] = int'(cfg);
    @(negedge QCK);
    wr_valid = 1'b0;
  endtask

  // Commit at cycle T (k=0) and check every output for k=1..21.
  task automatic run_commit(input string tag, input bit same_wr, input int same_idx,
                            input logic [3:0] same_cfg, input int rst_cycle,
                            input bit poke_commit, input bit poke_write);
    logic seq [BITS];
    logic e_fix, e_shift, e_latch, e_done, e_sdo;
    int   latch_seen;
    @(negedge QCK);
    total++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_pre busy=%b ready=%b want busy=0 ready=1", tag, busy, wr_ready);
    end
    commit = 1'b1;
    if (same_wr) begin
      wr_valid = 1'b1;
      wr_idx   = same_idx[1:0];
      wr_cfg   = same_cfg;
      model[same_idx] = int'(same_cfg);
    end
    for (int j = 0; j < BITS; j++) seq[j] = exp_bit(j);
    for (int k = 1; k <= 21; k++) begin
      @(negedge QCK);
      commit   = 1'b0;
      wr_valid = 1'b0;
      e_fix   = (k >= 1 && k <= 19);
      e_shift = (k >= 2 && k <= 17);
      e_latch = (k == 18);
      e_done  = (k == 19);
      e_sdo   = e_shift ? seq[k-2] : 1'b0;
      total++;
      if (fixhold !== e_fix || busy !== e_fix) begin
        bad++;
        $display("FAIL %s_fixhold k=%0d got fix=%b busy=%b want %b", tag, k, fixhold, busy, e_fix);
      end
      total++;
      if (wr_ready !== !e_fix) begin
        bad++;
        $display("FAIL %s_ready k=%0d got=%b want=%b", tag, k, wr_ready, !e_fix);
      end
      total++;
      if (chain_shift !== e_shift || chain_latch !== e_latch || done !== e_done) begin
        bad++;
        $display("FAIL %s_ctrl k=%0d got shift=%b latch=%b done=%b want %b %b %b",
                 tag, k, chain_shift, chain_latch, done, e_shift, e_latch, e_done);
      end
      total++;
      if (chain_sdo !== e_sdo) begin
        bad++;
        $display("FAIL %s_sdo k=%0d got=%b want=%b", tag, k, chain_sdo, e_sdo);
      end
      if (rst_cycle != 0 && k == rst_cycle) begin
        QRT = 1'b1;
        #1;
        model_reset();
        total++;
        if ({busy, done, chain_sdo, chain_shift, chain_latch, fixhold} !== 6'b0 || wr_ready !== 1'b1) begin
          bad++;
          $display("FAIL %s_abort got busy=%b done=%b sdo=%b shift=%b latch=%b fix=%b ready=%b want all 0 ready 1",
                   tag, busy, done, chain_sdo, chain_shift, chain_latch, fixhold, wr_ready);
        end
        @(negedge QCK);
        QRT = 1'b0;
        latch_seen = 0;
        for (int c = 0; c < 20; c++) begin
          @(negedge QCK);
          if (chain_latch || busy) latch_seen++;
        end
        total++;
        if (latch_seen != 0) begin
          bad++;
          $display("FAIL %s_no_latch got=%0d active cycles want=0", tag, latch_seen);
        end
        return;
      end
      if (poke_commit && (k == 1 || k == 18)) commit = 1'b1;
      if (poke_write && k == 5) begin
        wr_valid = 1'b1;
        wr_idx   = 2'($urandom_range(0, N-1));
        wr_cfg   = 4'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    QRT = 1'b1; wr_valid = 1'b0; wr_idx = '0; wr_cfg = '0; commit = 1'b0;
    model_reset();
    repeat (2) @(negedge QCK);
    total++;
    if ({busy, done, chain_sdo, chain_shift, chain_latch, fixhold} !== 6'b0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_outputs busy=%b done=%b sdo=%b shift=%b latch=%b fix=%b ready=%b",
               busy, done, chain_sdo, chain_shift, chain_latch, fixhold, wr_ready);
    end
    QRT = 1'b0;
  endtask

  task automatic test_zero_commit();
    run_commit("zero", 1'b0, 0, 4'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_pattern();
    logic [15:0] want, got;
    write_io(0, 4'hA);
    write_io(3, 4'h5);
    for (int j = 0; j < BITS; j++) got[15-j] = exp_bit(j);
    want = 16'b0101_0000_0000_1010;
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL pattern_model got=%b want=%b", got, want);
    end
    run_commit("pattern", 1'b0, 0, 4'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_write_blocked();
    run_commit("blocked1", 1'b0, 0, 4'h0, 0, 1'b0, 1'b1);
    run_commit("blocked2", 1'b0, 0, 4'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_same_cycle();
    run_commit("same", 1'b1, 1, 4'hF, 0, 1'b0, 1'b0);
  endtask

  task automatic test_commit_ignored();
    run_commit("ignored", 1'b0, 0, 4'h0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    write_io(2, 4'h9);
    run_commit("abort", 1'b0, 0, 4'h0, 6, 1'b0, 1'b0);
    run_commit("after_abort", 1'b0, 0, 4'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 3)) write_io($urandom_range(0, N-1), 4'($urandom));
      run_commit("rand", 1'($urandom), $urandom_range(0, N-1), 4'($urandom), 0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_zero_commit();
    test_pattern();
    test_write_blocked();
    test_same_cycle();
    test_commit_ignored();
    test_reset_mid_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ioreg_cfg_loader.md
IOREG_CFG_LOADER -- requirements
Module: ioreg_cfg_loader

Interface
REQ-001 SHALL have parameter NUM_IO, default 32, number of ioreg instances on the config chain (2..256).
REQ-002 SHALL have parameter RST_CFG, default 4'b0000, per-IO shadow value after reset (all IOs input-disabled, output-deselected).
REQ-003 SHALL have port QCK  in  1  sole clock; all state rising-edge.
REQ-004 SHALL have port QRT  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_valid  in  1  shadow write request.
REQ-006 SHALL have port wr_ready  out  1  shadow write accepted when high with wr_valid.
REQ-007 SHALL have port wr_idx  in  IDX_W=max(1,clog2(NUM_IO))  target IO index.
REQ-008 SHALL have port wr_cfg  in  4  config {INEN,OQE,OSEL,ESEL}, bit3..bit0.
REQ-009 SHALL have port commit  in  1  single-cycle request to push the shadow onto the chain.
REQ-010 SHALL have port busy  out  1  high while not IDLE.
REQ-011 SHALL have port done  out  1  single-cycle completion pulse.
REQ-012 SHALL have port chain_sdo  out  1  serial config data to ioreg chain.
REQ-013 SHALL have port chain_shift  out  1  chain shift enable, one bit per cycle.
REQ-014 SHALL have port chain_latch  out  1  single-cycle transfer of chain into ioreg active config.
REQ-015 SHALL have port fixhold  out  1  drives ioreg FIXHOLD; freezes pads during reload.

Function
REQ-016 SHALL hold shadow store NUM_IO x 4 flops; write when wr_valid&&wr_ready; wr_idx>=NUM_IO SHALL be accepted and discarded.
REQ-017 SHALL drive wr_ready = !busy (combinational from state).
REQ-018 SHALL implement states IDLE, FREEZE, SHIFT, LATCH, RELEASE.
REQ-019 IDLE->FREEZE on commit; FREEZE->SHIFT after 1 cycle; SHIFT->LATCH after exactly 4*NUM_IO cycles; LATCH->RELEASE after 1 cycle; RELEASE->IDLE after 1 cycle.
REQ-020 SHALL assert fixhold in FREEZE, SHIFT, LATCH, RELEASE; low in IDLE.
REQ-021 SHALL assert chain_shift only in SHIFT, chain_latch only in LATCH, done only in RELEASE; busy high for 4*NUM_IO+3 cycles per commit.
REQ-022 SHALL shift order IO NUM_IO-1 first, bit3 first within each IO; last bit shifted is IO0 bit0.
REQ-023 chain_sdo SHALL be registered, valid in every SHIFT cycle, 0 outside SHIFT.
REQ-024 SHALL serialise from a snapshot taken on entry to FREEZE; shadow writes are blocked while busy, so the snapshot equals the shadow.
REQ-025 Same-cycle commit and accepted write in IDLE: the write SHALL land first and be included in the shift.
REQ-026 commit while busy SHALL be ignored (not queued).
REQ-027 Bit counter SHALL be width clog2(4*NUM_IO) and SHALL terminate exactly at 4*NUM_IO-1 with no wrap into a further cycle.

Reset
REQ-028 QRT high SHALL immediately force: state IDLE, shadow=RST_CFG for all IOs, counter 0, busy/done/chain_sdo/chain_shift/chain_latch/fixhold 0, wr_ready 1.
REQ-029 Reset mid-SHIFT SHALL abort without chain_latch; ioreg active config stays as previously latched.
REQ-030 First commit after reset release SHALL operate normally.

Structure
REQ-031 Shared package ioreg_cfg_pkg SHALL hold CFG_W=4, field indices (ESEL=0, OSEL=1, OQE=2, INEN=3), and the state enum.
REQ-032 Parallel-to-serial path (snapshot, bit counter, chain_sdo) SHALL be sub-module ioreg_cfg_ser; FSM and shadow stay in top.

Verification (NUM_IO=4)
REQ-033 Reset, commit at T -> fixhold high T+1..T+19, chain_shift T+2..T+17 with sdo all 0, chain_latch T+18, done T+19, busy low T+20.
REQ-034 Write IO0=4'hA, IO3=4'h5, commit -> sdo sequence 0101 0000 0000 1010.
REQ-035 wr_valid during SHIFT -> wr_ready 0, shadow unchanged; next commit reproduces prior sequence.
REQ-036 Same-cycle commit + write IO1=4'hF in IDLE -> sdo bits 8..11 = 1111.
REQ-037 QRT pulse at 5th SHIFT cycle -> all outputs 0 at once, no chain_latch, shadow=RST_CFG; later commit shifts all zeros.
REQ-038 commit pulses at FREEZE and LATCH -> ignored, single done, busy exactly 19 cycles.
